// File: rtl/iq_mod.sv
// iq_mod: fs/4 quadrature upconverter (baseband I/Q times e^{j*pi*p/2}) with burst-aligned phase.
module iq_mod #(
  parameter int W            = 5,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] I_BB,
  input  logic [W-1:0] Q_BB,
  input  logic         bb_rdy,
  input  logic         sync,
  output logic [W-1:0] I_IF,
  output logic [W-1:0] Q_IF,
  output logic         mod_rdy,
  output logic         sat,
  output logic         active
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
  state_t       state_q;
  logic [1:0]   p_q, ph;
  logic [7:0]   cnt_q;
  logic [W-1:0] i_q, q_q, i_d, q_d, ni, nq;
  logic         rdy_q, sat_q, s_d, ni_sat, nq_sat, timeout;
  always_comb begin
    ph      = (state_q == IDLE || sync) ? 2'd0 : p_q;
    ni_sat  = I_BB == MIN;
    nq_sat  = Q_BB == MIN;
    ni      = ni_sat ? MAX : ~I_BB + 1'b1;
    nq      = nq_sat ? MAX : ~Q_BB + 1'b1;
    i_d     = ph == 2'd0 ? I_BB : ph == 2'd1 ? nq   : ph == 2'd2 ? ni : Q_BB;
    q_d     = ph == 2'd0 ? Q_BB : ph == 2'd1 ? I_BB : ph == 2'd2 ? nq : ni;
    s_d     = ph == 2'd1 ? nq_sat : ph == 2'd2 ? (ni_sat | nq_sat) : ph == 2'd3 ? ni_sat : 1'b0;
    // the counter would hit IDLE_TIMEOUT on this edge
    timeout = state_q == RUN && !bb_rdy && cnt_q == 8'(IDLE_TIMEOUT - 1);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      p_q     <= '0;
      cnt_q   <= '0;
      i_q     <= '0;
      q_q     <= '0;
      rdy_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      rdy_q <= bb_rdy;
      sat_q <= bb_rdy & s_d;
      if (bb_rdy) begin
        state_q <= RUN;
        p_q     <= ph + 2'd1;
        cnt_q   <= '0;
        i_q     <= i_d;
        q_q     <= q_d;
      end else if (timeout) begin
        state_q <= IDLE;
        p_q     <= '0;
        cnt_q   <= '0;
        i_q     <= '0;
        q_q     <= '0;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end
  assign I_IF    = i_q;
  assign Q_IF    = q_q;
  assign mod_rdy = rdy_q;
  assign sat     = sat_q;
  assign active  = state_q == RUN;
endmodule
